// File: rtl/prio_bit_serializer_pkg.sv
// Shared types and helpers for the priority bit serializer.
package prio_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int MAX_N = 64;

    // Counts set bits among the low n bits of v; callers zero-extend to MAX_N.
    function automatic logic [6:0] popcount(input logic [MAX_N-1:0] v, input int n);
        logic [6:0] c;
        c = 7'd0;
        for (int i = 0; i < MAX_N; i++) begin
            c = c + ((i < n) ? 7'(v[i]) : 7'd0);
        end
        return c;
    endfunction

endpackage

// File: rtl/prio_bit_serializer_if.sv
// Request/beat handshake bundle between producer, serializer and consumer.
interface prio_bit_serializer_if #(
    parameter int N = 8,
    parameter int W = $clog2(N)
);
    logic [N-1:0] in;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] pos;
    logic         none;
    logic         last;
    logic [W:0]   cnt;
    logic         out_valid;
    logic         out_ready;

    modport slave (
        input  in, in_valid, out_ready,
        output in_ready, pos, none, last, cnt, out_valid
    );

    modport master (
        output in, in_valid, out_ready,
        input  in_ready, pos, none, last, cnt, out_valid
    );
endinterface

// File: rtl/prio_enc.sv
// Combinational N-bit priority encoder; also the drop-in for the legacy 4-bit encoder.
module prio_enc #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b0,
    localparam int W        = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan toward the highest-priority end so the last hit wins.
    always_comb begin
        idx = {W{1'b0}};
        any = 1'b0;
        if (MSB_FIRST) begin
            for (int i = 0; i < N; i++) begin
                idx = vec[i] ? W'(i) : idx;
                any = any | vec[i];
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                idx = vec[i] ? W'(i) : idx;
                any = any | vec[i];
            end
        end
    end

endmodule

// File: rtl/prio_bit_serializer.sv
// Captures a request vector and emits the index of each set bit, one beat per handshake.
module prio_bit_serializer
    import prio_pkg::*;
#(
    parameter int N         = 8,
    parameter int W         = $clog2(N),
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                  clk,
    input  logic                  areset,
    prio_bit_serializer_if.slave  bus
);

    state_t       state_r, state_s;
    logic [N-1:0] pend_r, pend_s;
    logic [W:0]   cnt_r, cnt_s;
    logic         empty_r, empty_s;

    logic [W-1:0] enc_idx_s;
    logic         enc_any_s;
    logic         last_s;
    logic         scan_s;

    prio_enc #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_enc (
        .vec (pend_r),
        .idx (enc_idx_s),
        .any (enc_any_s)
    );

    // At most one pending bit (zero or a power of two) marks the final beat.
    assign last_s = ((pend_r & (pend_r - N'(1))) == {N{1'b0}});
    assign scan_s = (state_r == SCAN);

    // Next-state and capture/clear logic.
    always_comb begin
        state_s = state_r;
        pend_s  = pend_r;
        cnt_s   = cnt_r;
        empty_s = empty_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    state_s = SCAN;
                    pend_s  = bus.in;
                    cnt_s   = (W+1)'(popcount(MAX_N'(bus.in), N));
                    empty_s = (bus.in == {N{1'b0}});
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (bus.out_ready) begin
                    pend_s  = pend_r & ~(N'(1) << enc_idx_s);
                    state_s = last_s ? IDLE : SCAN;
                end else begin
                    state_s = SCAN;
                end
            end
            default: begin
                state_s = IDLE;
                pend_s  = {N{1'b0}};
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_r <= IDLE;
            pend_r  <= {N{1'b0}};
            cnt_r   <= {(W+1){1'b0}};
            empty_r <= 1'b0;
        end else begin
            state_r <= state_s;
            pend_r  <= pend_s;
            cnt_r   <= cnt_s;
            empty_r <= empty_s;
        end
    end

    // Beat fields come from registers only and read as zero outside SCAN.
    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = scan_s;
    assign bus.pos       = (scan_s && enc_any_s) ? enc_idx_s : {W{1'b0}};
    assign bus.last      = scan_s & last_s;
    assign bus.none      = scan_s & empty_r;
    assign bus.cnt       = cnt_r;

endmodule

// File: tb/tb_prio_bit_serializer.sv
// Directed bench: LSB-first and MSB-first instances driven by identical stimulus.
module tb_prio_bit_serializer;

    logic       clk = 1'b0;
    logic       areset;
    logic [7:0] in_v;
    logic       in_valid_v;
    logic       out_ready_v;

    int n_vec  = 0;
    int n_fail = 0;

    prio_bit_serializer_if #(.N(8)) if_l ();
    prio_bit_serializer_if #(.N(8)) if_m ();

    assign if_l.in        = in_v;
    assign if_l.in_valid  = in_valid_v;
    assign if_l.out_ready = out_ready_v;
    assign if_m.in        = in_v;
    assign if_m.in_valid  = in_valid_v;
    assign if_m.out_ready = out_ready_v;

    prio_bit_serializer #(.N(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .areset(areset), .bus(if_l));
    prio_bit_serializer #(.N(8), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .areset(areset), .bus(if_m));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]       vec;
        logic [3:0]       cnt;
        int               nb;
        logic [0:7][2:0]  lsb;
        logic [0:7][2:0]  msb;
    } vec_t;

    vec_t tab [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_chk(input string tag, input logic [3:0] exp_cnt);
        chk({tag, " in_ready_l"}, 32'(if_l.in_ready), 32'd1);
        chk({tag, " out_valid_l"}, 32'(if_l.out_valid), 32'd0);
        chk({tag, " out_valid_m"}, 32'(if_m.out_valid), 32'd0);
        chk({tag, " pos_l"}, 32'(if_l.pos), 32'd0);
        chk({tag, " none_l"}, 32'(if_l.none), 32'd0);
        chk({tag, " last_l"}, 32'(if_l.last), 32'd0);
        chk({tag, " cnt_l"}, 32'(if_l.cnt), 32'(exp_cnt));
    endtask

    // Accept one vector with out_ready high and check every beat in both orders.
    task automatic run_vector(input vec_t v);
        @(negedge clk);
        chk("accept in_ready", 32'(if_l.in_ready), 32'd1);
        in_v        = v.vec;
        in_valid_v  = 1'b1;
        out_ready_v = 1'b1;
        @(negedge clk);
        in_valid_v = 1'b0;
        chk("first out_valid", 32'(if_l.out_valid), 32'd1);
        chk("scan in_ready", 32'(if_m.in_ready), 32'd0);
        chk("cnt", 32'(if_l.cnt), 32'(v.cnt));
        for (int b = 0; b < v.nb; b++) begin
            chk("beat valid_l", 32'(if_l.out_valid), 32'd1);
            chk("beat pos_l", 32'(if_l.pos), 32'(v.lsb[b]));
            chk("beat pos_m", 32'(if_m.pos), 32'(v.msb[b]));
            chk("beat last_l", 32'(if_l.last), (b == v.nb - 1) ? 32'd1 : 32'd0);
            chk("beat last_m", 32'(if_m.last), (b == v.nb - 1) ? 32'd1 : 32'd0);
            chk("beat none_l", 32'(if_l.none), (v.vec == 8'h00) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        idle_chk("after vector", v.cnt);
    endtask

    initial begin
        tab[0] = '{vec: 8'hA4, cnt: 4'd3, nb: 3,
                   lsb: '{3'd2, 3'd5, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                   msb: '{3'd7, 3'd5, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
        tab[1] = '{vec: 8'h00, cnt: 4'd0, nb: 1,
                   lsb: '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                   msb: '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
        tab[2] = '{vec: 8'h01, cnt: 4'd1, nb: 1,
                   lsb: '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                   msb: '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
        tab[3] = '{vec: 8'h80, cnt: 4'd1, nb: 1,
                   lsb: '{3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                   msb: '{3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
        tab[4] = '{vec: 8'hFF, cnt: 4'd8, nb: 8,
                   lsb: '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7},
                   msb: '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
        tab[5] = '{vec: 8'h5A, cnt: 4'd4, nb: 4,
                   lsb: '{3'd1, 3'd3, 3'd4, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0},
                   msb: '{3'd6, 3'd4, 3'd3, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0}};

        areset      = 1'b1;
        in_v        = 8'h00;
        in_valid_v  = 1'b0;
        out_ready_v = 1'b0;
        repeat (2) @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        idle_chk("reset", 4'd0);

        for (int i = 0; i < 6; i++) begin
            run_vector(tab[i]);
        end

        // Backpressure on 8'h81 with a stray in_valid pulse that must be ignored.
        in_v        = 8'h81;
        in_valid_v  = 1'b1;
        out_ready_v = 1'b0;
        @(negedge clk);
        in_valid_v = 1'b0;
        chk("bp cnt", 32'(if_l.cnt), 32'd2);
        for (int k = 0; k < 3; k++) begin
            chk("bp valid", 32'(if_l.out_valid), 32'd1);
            chk("bp pos_l", 32'(if_l.pos), 32'd0);
            chk("bp pos_m", 32'(if_m.pos), 32'd7);
            chk("bp last_l", 32'(if_l.last), 32'd0);
            chk("bp in_ready", 32'(if_l.in_ready), 32'd0);
            in_v       = 8'hFF;
            in_valid_v = (k == 1);
            @(negedge clk);
        end
        in_valid_v  = 1'b0;
        out_ready_v = 1'b1;
        chk("bp hold cnt", 32'(if_l.cnt), 32'd2);
        chk("bp beat0 pos_l", 32'(if_l.pos), 32'd0);
        @(negedge clk);
        chk("bp beat1 pos_l", 32'(if_l.pos), 32'd7);
        chk("bp beat1 pos_m", 32'(if_m.pos), 32'd0);
        chk("bp beat1 last_l", 32'(if_l.last), 32'd1);
        @(negedge clk);
        idle_chk("bp done", 4'd2);

        // Asynchronous reset after the third beat of 8'hFF.
        in_v       = 8'hFF;
        in_valid_v = 1'b1;
        @(negedge clk);
        in_valid_v = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-reset pos_l", 32'(if_l.pos), 32'd3);
        #2 areset = 1'b1;
        #1;
        chk("async drop valid_l", 32'(if_l.out_valid), 32'd0);
        chk("async drop valid_m", 32'(if_m.out_valid), 32'd0);
        chk("async drop pos_l", 32'(if_l.pos), 32'd0);
        @(negedge clk);
        chk("in reset valid", 32'(if_l.out_valid), 32'd0);
        chk("in reset cnt", 32'(if_l.cnt), 32'd0);
        areset = 1'b0;
        @(negedge clk);
        idle_chk("post reset", 4'd0);
        run_vector('{vec: 8'h10, cnt: 4'd1, nb: 1,
                     lsb: '{3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                     msb: '{3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/prio_bit_serializer.md
Name: prio_bit_serializer

Overview:
Parametrised successor to the 4-bit combinational position encoder. It captures an N-bit request vector through a valid/ready handshake and emits the index of every set bit, one per output beat. Emission order is highest-priority first: LSB-first or MSB-first, chosen by parameter. It sits between request-collection logic and a downstream consumer that services one index at a time.

Parameters:
N, 8, request vector width (2..64)
W, $clog2(N), index width (derived; do not override)
MSB_FIRST, 0, 0: bit 0 has highest priority; 1: bit N-1 has highest priority

Ports:
clk  in  1  clock, rising edge
areset  in  1  asynchronous, active-high reset
in  in  N  request vector
in_valid  in  1  request vector valid
in_ready  out  1  block can accept a vector
pos  out  W  index of current highest-priority pending bit
none  out  1  captured vector was all-zero (single beat)
last  out  1  current beat is the final beat of this vector
cnt  out  W+1  population count of the captured vector
out_valid  out  1  pos/none/last valid
out_ready  in  1  consumer accepts beat

Behaviour:
- Single clock domain (clk). Reset is asynchronous and active-high (areset). The handshake below is fixed.
- Reset: state=IDLE, pend=0, cnt=0, empty flag=0. Resulting outputs: in_ready=1, out_valid=0, pos=0, none=0, last=0, cnt=0.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SCAN: in_ready=0, out_valid=1.
- IDLE -> SCAN when in_valid=1 at a clk edge.
  - pend <= in; cnt <= popcount(in); empty flag <= (in==0).
  - First out_valid appears the cycle after the accept (1-cycle latency).
- In SCAN, pos/none/last are combinational from registers only (pend, empty flag); no combinational path from in or out_ready.
  - pos = index of highest-priority set bit of pend per MSB_FIRST.
  - last = (at most one bit set in pend).
  - none = empty flag; when none=1, pos=0 and last=1.
- Beat transfer: out_valid && out_ready at a clk edge.
  - Clear the pos bit in pend.
  - If last=1, go SCAN -> IDLE. in_ready rises the cycle after the final transfer; there are no back-to-back vectors.
- Backpressure: while out_valid=1 and out_ready=0, pos/none/last/cnt hold stable. Minimum of 1 beat per cycle when out_ready stays high.
- in_valid in SCAN is ignored; in is not sampled.
- Whenever out_valid=0, pos/none/last are forced to 0. cnt holds its last captured value until the next accept.
- Vector of N ones: N beats, indices in strict priority order, last only on the Nth beat.
- areset mid-scan: out_valid drops immediately (asynchronously) and pend clears. No partial beat is emitted after release.
- Width rules: cnt is W+1 bits so it can hold N. pos never exceeds N-1.

Decomposition:
- Shared package prio_pkg:
  - state typedef {IDLE, SCAN}.
  - popcount function, parametrised on N.
- One natural sub-module: prio_enc.
  - Purely combinational N-bit priority encoder.
  - Parameters N, MSB_FIRST.
  - Outputs idx[W-1:0] and any.
  - Instantiated once on pend.
  - Must also be reused wherever the legacy 4-bit encoder is replaced.

Test Plan:
- Assert areset for 2 cycles, then release -> in_ready=1, out_valid=0, pos=0, none=0, last=0, cnt=0.
- N=8, MSB_FIRST=0, in=8'b1010_0100, out_ready=1 -> cnt=3; beats pos=2,5,7 on consecutive cycles; last=1 only with pos=7; in_ready=1 the following cycle.
- Same vector with MSB_FIRST=1 -> beats pos=7,5,2; last on pos=2.
- in=8'h00 -> exactly one beat with none=1, pos=0, last=1, cnt=0, then IDLE.
- in=8'h81, out_ready low for 3 cycles after out_valid rises -> pos=0 held for 3 cycles; in_valid pulsed with 8'hFF meanwhile is ignored; then beats 0,7.
- in=8'hFF, areset asserted mid-cycle after the 3rd beat -> out_valid=0 immediately, no further beats; after release, a new vector 8'h10 yields a single beat pos=4, last=1.
